// File: rtl/seq_mux_pkg.sv
// Shared types and constants for the seq_mux_rr registered multiplexer.
package seq_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Channel-index width; never narrower than one bit.
    function automatic int unsigned sel_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_mux_rr_if.sv
// Channel-side and sink-side handshake bundle for seq_mux_rr.
// slave: the multiplexer; master: the sources/sink driving it.
interface seq_mux_rr_if
    import seq_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4
);
    localparam int unsigned SELW = sel_width(NCH);

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_chan;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after ptr wins,
// scanning upward with wrap-around modulo NCH.
module rr_arbiter
    import seq_mux_pkg::*;
#(
    parameter  int unsigned NCH  = 4,
    localparam int unsigned SELW = sel_width(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    logic [SELW-1:0] idx;

    // Priority scan starting one past the last winner.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = SELW'((32'(ptr) + k) % NCH);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/seq_mux_rr.sv
// NCH:1 registered multiplexer with valid/ready handshake, fixed-select or
// round-robin arbitration and a single output register stage.
// Optional: define SEQ_MUX_STATS_EN to add the saturating xfer_cnt output.
module seq_mux_rr
    import seq_mux_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned NCH   = 4,
    localparam int unsigned SELW  = sel_width(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  mode_e           mode,
    input  logic [SELW-1:0] sel,
    seq_mux_rr_if.slave     bus
`ifdef SEQ_MUX_STATS_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt
`endif
);

    logic [NCH-1:0]   rr_gnt;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;
    logic [NCH-1:0]   fix_gnt;
    logic [NCH-1:0]   gnt;
    logic [SELW-1:0]  gnt_idx;
    logic             any_gnt;
    logic             load_en;
    logic             xfer;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_chan_q;
    logic [SELW-1:0]  rr_ptr_q;

    rr_arbiter #(
        .NCH(NCH)
    ) u_arb (
        .req    (bus.in_valid),
        .ptr    (rr_ptr_q),
        .gnt    (rr_gnt),
        .gnt_idx(rr_idx),
        .any    (rr_any)
    );

    // Fixed-select decode; an out-of-range sel grants nobody.
    always_comb begin
        fix_gnt = '0;
        if ({1'b0, sel} < (SELW + 1)'(NCH)) begin
            fix_gnt[sel] = bus.in_valid[sel];
        end
    end

    // Grant selection and handshake; the output register may drain and
    // refill in the same cycle.
    always_comb begin
        if (mode == MODE_RR) begin
            gnt     = rr_gnt;
            gnt_idx = rr_idx;
            any_gnt = rr_any;
        end else begin
            gnt     = fix_gnt;
            gnt_idx = sel;
            any_gnt = |fix_gnt;
        end
        load_en      = !out_valid_q || bus.out_ready;
        xfer         = any_gnt && load_en && !rst;
        bus.in_ready = gnt & {NCH{load_en && !rst}};
    end

    // Output register stage and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= SELW'(NCH - 1);
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data[32'(gnt_idx) * WIDTH +: WIDTH];
            out_chan_q  <= gnt_idx;
            // Pointer only advances on round-robin wins so FIXED periods keep it.
            if (mode == MODE_RR) begin
                rr_ptr_q <= gnt_idx;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

`ifdef SEQ_MUX_STATS_EN
    logic [CNT_W-1:0] xfer_cnt_q;

    // Saturating count of output handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else if (out_valid_q && bus.out_ready && (xfer_cnt_q != CNT_MAX)) begin
            xfer_cnt_q <= xfer_cnt_q + 1'b1;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
